// File: rtl/led_disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display arbiter.
// Segment and anode drives are active-high.
package led_disp_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK  = 8'h00;
    localparam int   MAX_DIGITS = 32;

    // Any mode_sel value at or above the source count means the display is off.
    function automatic logic is_off(input int unsigned sel, input int unsigned n_src);
        return sel >= n_src;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_DIGITS) v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_display_arbiter_scan.sv
// Digit-slot timer: scan_cnt paces each slot, digit_idx walks the digits and
// wrap marks the last tick of a full scan frame.
module led_scan_timer #(
    parameter int SCAN_DIV     = 100000,
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 2,
    localparam int CNT_W       = $clog2(SCAN_DIV),
    localparam int DIG_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic             wrap,
    output logic [DIG_W-1:0] digit_idx,
    output logic             in_blank
);

    logic [CNT_W-1:0] scan_cnt;
    logic             last_digit;

    assign tick       = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (digit_idx == DIG_W'(N_DIGITS - 1));
    assign wrap       = tick & last_digit;
    assign in_blank   = (scan_cnt < CNT_W'(BLANK_CYCLES));

    // NOTE: registers take <= so every flop samples pre-edge values; = here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            scan_cnt  <= '0;
            digit_idx <= last_digit ? '0 : digit_idx + DIG_W'(1);
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Multiplexed 7-segment controller: per-frame source snapshot, per-digit blink,
// anti-ghost anode blanking and a timed high-priority overlay.
module led_display_arbiter
    import led_disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int N_SRC        = 2,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_DIV    = 25000000,
    parameter int OVL_HOLD     = 200000000,
    localparam int SEL_W       = $clog2(N_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          mode_sel,
    input  logic [N_SRC*N_DIGITS*8-1:0] src_seg,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_DIGITS-1:0]       blink_mask,
    input  logic                      ovl_req,
    input  logic [N_DIGITS*8-1:0]     ovl_seg,
    output logic                      ovl_active,
    output logic [7:0]                seg,
    output logic [N_DIGITS-1:0]       an,
    output logic                      frame_start
);

    localparam int DIG_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int OVL_W   = $clog2(OVL_HOLD + 1);
    localparam int FRAME_W = N_DIGITS * 8;

    logic             tick;
    logic             wrap;
    logic             in_blank;
    logic             load_frame;
    logic [DIG_W-1:0] digit_idx;

    logic [FRAME_W-1:0] frame_buf;
    logic [FRAME_W-1:0] sel_frame;
    logic [SEL_W-1:0]   cur_mode;
    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_hidden;
    logic [FRAME_W-1:0] ovl_buf;
    logic [OVL_W-1:0]   ovl_timer;

    seg_t                frame_byte;
    seg_t                ovl_byte;
    seg_t                seg_d;
    logic [N_DIGITS-1:0] an_d;
    logic [N_DIGITS-1:0] digit_onehot;
    logic                mode_off;

    led_scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .N_DIGITS    (N_DIGITS),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .wrap     (wrap),
        .digit_idx(digit_idx),
        .in_blank (in_blank)
    );

    assign load_frame = tick & wrap;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_frame = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (mode_sel == SEL_W'(k) && src_valid[k]) sel_frame = src_seg[k*FRAME_W +: FRAME_W];
        end
    end

    always_comb begin
        frame_byte   = frame_buf[{digit_idx, 3'b000} +: 8];
        ovl_byte     = ovl_buf[{digit_idx, 3'b000} +: 8];
        digit_onehot = N_DIGITS'(onehot(32'(digit_idx), N_DIGITS));
        mode_off     = is_off(32'(cur_mode), N_SRC);
        seg_d        = frame_byte;
        an_d         = in_blank ? '0 : digit_onehot;
        if (ovl_active) begin
            seg_d = ovl_byte;
        end else if (mode_off) begin
            seg_d = SEG_BLANK;
            an_d  = '0;
        end else if (blink_hidden && blink_mask[digit_idx]) begin
            seg_d = SEG_BLANK;
        end
    end

    // NOTE: the frame and overlay buffers are plain registers and are cleared on reset, unlike RAM arrays.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg          <= SEG_BLANK;
            an           <= '0;
            frame_start  <= 1'b0;
            frame_buf    <= '0;
            cur_mode     <= '0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            ovl_buf      <= '0;
            ovl_timer    <= '0;
            ovl_active   <= 1'b0;
        end else begin
            seg         <= seg_d;
            an          <= an_d;
            frame_start <= load_frame;

            if (load_frame) begin
                frame_buf <= sel_frame;
                cur_mode  <= mode_sel;
            end

            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt    <= blink_cnt + BLK_W'(1);
            end

            // Timer holds the remaining visible cycles; a request always wins over expiry.
            if (ovl_req) begin
                ovl_buf    <= ovl_seg;
                ovl_timer  <= OVL_W'(OVL_HOLD);
                ovl_active <= 1'b1;
            end else if (ovl_active) begin
                ovl_timer <= ovl_timer - OVL_W'(1);
                if (ovl_timer == OVL_W'(1)) ovl_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Scoreboard bench: the driver pushes the expected outputs for each clock edge,
// a monitor pops and compares them just after that edge.
module tb_led_display_arbiter;

    localparam logic [31:0] P0  = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    localparam logic [31:0] P1  = {8'h6D, 8'h7D, 8'h07, 8'h7F};
    localparam logic [31:0] OVA = {4{8'h79}};
    localparam logic [31:0] OVB = {8'h08, 8'h04, 8'h02, 8'h01};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_sel;
    logic [63:0] src_seg;
    logic [1:0]  src_valid;
    logic [3:0]  blink_mask;
    logic        ovl_req;
    logic [31:0] ovl_seg;
    logic        ovl_active;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic       ovl;
        logic       fs;
        string      name;
        int         k;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    bit   drive_done = 1'b0;

    led_display_arbiter #(
        .N_DIGITS(4), .N_SRC(2), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(64), .OVL_HOLD(40)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_sel   (mode_sel),
        .src_seg    (src_seg),
        .src_valid  (src_valid),
        .blink_mask (blink_mask),
        .ovl_req    (ovl_req),
        .ovl_seg    (ovl_seg),
        .ovl_active (ovl_active),
        .seg        (seg),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int d);
        return w[d*8 +: 8];
    endfunction

    // Content of scan frame f in the main run (frame f covers edges 16f..16f+15).
    function automatic void frame_main(input int f, output logic [31:0] pat, output bit off);
        off = 1'b0;
        pat = '0;
        if (f == 1)                pat = P0;
        else if (f == 2)           pat = P1;
        else if (f == 4 || f >= 13) off = 1'b1;
        else if (f >= 5)           pat = P1;
    endfunction

    function automatic bit ovl_on_main(input int k);
        return (k >= 160 && k <= 229) || (k >= 260 && k <= 264);
    endfunction

    function automatic string phase_name(input int k, input bit post);
        if (post)     return "post_reset";
        if (k < 16)   return "scan_first_frame";
        if (k < 48)   return "src0_frames";
        if (k < 80)   return "invalid_and_off";
        if (k < 160)  return "blink";
        if (k < 250)  return "overlay_retrigger";
        return "overlay_digits";
    endfunction

    function automatic exp_t zeros(input string n, input int k);
        exp_t e;
        e.seg = 8'h00; e.an = 4'b0000; e.ovl = 1'b0; e.fs = 1'b0;
        e.name = n; e.k = k;
        return e;
    endfunction

    // Expected outputs after edge k counted from reset release.
    function automatic exp_t build_exp(input int k, input bit post, input logic [3:0] mask);
        exp_t        e;
        int          d;
        logic [31:0] pat;
        logic [31:0] opat;
        bit          off;
        bit          ov_prev;
        bit          ov_now;
        bit          hidden;
        d = (k / 4) % 4;
        if (post) begin
            pat = '0; off = (k / 16) >= 1; ov_prev = 1'b0; ov_now = 1'b0; opat = '0;
        end else begin
            frame_main(k / 16, pat, off);
            ov_now  = ovl_on_main(k);
            ov_prev = (k > 0) && ovl_on_main(k - 1);
            opat    = (k - 1 < 250) ? OVA : OVB;
        end
        hidden = ((k / 64) % 2) == 1;
        e.an   = ((k % 4) >= 1) ? 4'(1 << d) : 4'b0000;
        if (ov_prev) begin
            e.seg = byte_of(opat, d);
        end else if (off) begin
            e.seg = 8'h00;
            e.an  = 4'b0000;
        end else if (mask[d] && hidden) begin
            e.seg = 8'h00;
        end else begin
            e.seg = byte_of(pat, d);
        end
        e.ovl  = ov_now;
        e.fs   = (k % 16) == 15;
        e.name = phase_name(k, post);
        e.k    = k;
        return e;
    endfunction

    initial begin : driver
        rst        = 1'b1;
        mode_sel   = 2'd0;
        src_valid  = 2'b01;
        src_seg    = {32'hFFFF_FFFF, P0};
        blink_mask = 4'b0010;
        ovl_req    = 1'b0;
        ovl_seg    = 32'h0;

        repeat (3) begin
            @(negedge clk);
            q.push_back(zeros("reset_hold", -1));
        end

        for (int k = 0; k <= 265; k++) begin
            @(negedge clk);
            rst     = 1'b0;
            ovl_req = 1'b0;
            ovl_seg = 32'hFFFF_FFFF;
            case (k)
                20:       src_seg[31:0] = P1;
                40:       mode_sel = 2'd1;
                56:       mode_sel = 2'd2;
                72:       mode_sel = 2'd0;
                160, 190: begin ovl_req = 1'b1; ovl_seg = OVA; end
                200:      mode_sel = 2'd2;
                260:      begin ovl_req = 1'b1; ovl_seg = OVB; end
                default:  ;
            endcase
            if (k == 265) begin
                rst = 1'b1;
                q.push_back(zeros("mid_reset", k));
            end else begin
                q.push_back(build_exp(k, 1'b0, blink_mask));
            end
        end

        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            rst     = 1'b0;
            ovl_seg = 32'hFFFF_FFFF;
            q.push_back(build_exp(k, 1'b1, blink_mask));
        end

        @(negedge clk);
        drive_done = 1'b1;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({seg, an, ovl_active, frame_start} !== {e.seg, e.an, e.ovl, e.fs}) begin
                    failures++;
                    $display("FAIL %s k=%0d got seg=%h an=%b ovl=%b fs=%b want seg=%h an=%b ovl=%b fs=%b",
                             e.name, e.k, seg, an, ovl_active, frame_start, e.seg, e.an, e.ovl, e.fs);
                end
            end
        end
    end

    initial begin : control
        int cyc;
        cyc = 0;
        while (!drive_done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (!drive_done) begin
            failures++;
            $display("FAIL timeout got cycles=%0d want driver finished", cyc);
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
